// File: rtl/npu_sched_loader.sv
// Config-stream loader for the NPU scheduler: parses header + schedule words, writes
// them into the scheduler buffer, then sequences read-enable bursts per invocation.
module npu_sched_loader #(
  parameter int SCHED_DEPTH = 64,
  parameter int LEN_W       = 7
) (
  input  logic        CLK,
  input  logic        npu_rst,
  input  logic        cfg_valid,
  input  logic [15:0] cfg_din,
  output logic        cfg_ready,
  input  logic        inv_start,
  output logic        npu_sched_write_en,
  output logic [15:0] npu_sched_din,
  output logic        npu_state_compute,
  output logic        npu_cfg_done,
  output logic        npu_inv_done,
  output logic        npu_busy,
  output logic        cfg_err,
  output logic [15:0] inv_count
);

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    S_HDR,
    S_LOAD,
    S_READY,
    S_COMPUTE,
    S_ERR
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   w_len_nxt;
  logic [LEN_W-1:0]   r_word_cnt;
  logic [LEN_W-1:0]   w_word_cnt_nxt;
  logic [LEN_W-1:0]   r_step_cnt;
  logic [LEN_W-1:0]   w_step_cnt_nxt;
  logic [LEN_W-1:0]   w_len_m1;
  logic               w_xfer;
  logic               w_wr_vld_p0;
  logic               w_inv_done_p0;
  logic               r_wr_vld_p1;
  logic [DATA_W-1:0]  r_wr_data_p1;
  logic               r_inv_done_p1;
  logic [15:0]        r_inv_count;

  // Header is malformed if the length is zero, exceeds the buffer, or stray high bits are set.
  function automatic logic f_hdr_bad(input logic [DATA_W-1:0] hdr);
    logic [LEN_W-1:0] len;
    len = hdr[LEN_W-1:0];
    return (len == '0) || (int'(len) > SCHED_DEPTH) || (hdr[DATA_W-1:LEN_W] != '0);
  endfunction

  assign cfg_ready   = (r_state == S_HDR) || (r_state == S_LOAD);
  assign w_xfer      = cfg_valid && cfg_ready;
  assign w_len_m1    = r_len - LEN_W'(1);
  assign w_wr_vld_p0 = w_xfer && (r_state == S_LOAD);

  always_comb begin
    w_state_nxt    = r_state;
    w_len_nxt      = r_len;
    w_word_cnt_nxt = r_word_cnt;
    w_step_cnt_nxt = r_step_cnt;
    w_inv_done_p0  = 1'b0;
    case (r_state)
      S_HDR: begin
        if (w_xfer) begin
          if (f_hdr_bad(cfg_din)) begin
            w_state_nxt = S_ERR;
          end else begin
            w_len_nxt      = cfg_din[LEN_W-1:0];
            w_word_cnt_nxt = '0;
            w_state_nxt    = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (w_xfer) begin
          w_word_cnt_nxt = r_word_cnt + LEN_W'(1);
          if (r_word_cnt == w_len_m1) w_state_nxt = S_READY;
        end
      end
      S_READY: begin
        if (inv_start) begin
          w_step_cnt_nxt = '0;
          w_state_nxt    = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        w_step_cnt_nxt = r_step_cnt + LEN_W'(1);
        // Last step: restart immediately if another invocation is requested, else idle.
        if (r_step_cnt == w_len_m1) begin
          w_inv_done_p0  = 1'b1;
          w_step_cnt_nxt = '0;
          if (!inv_start) w_state_nxt = S_READY;
        end
      end
      S_ERR: begin
        w_state_nxt = S_ERR;
      end
      default: begin
        w_state_nxt = S_ERR;
      end
    endcase
  end

  // p0 -> p1: state update, buffer write stage and invocation-complete strobe
  always_ff @(posedge CLK) begin
    if (npu_rst) begin
      r_state       <= S_HDR;
      r_len         <= '0;
      r_word_cnt    <= '0;
      r_step_cnt    <= '0;
      r_wr_vld_p1   <= 1'b0;
      r_wr_data_p1  <= '0;
      r_inv_done_p1 <= 1'b0;
      r_inv_count   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_len         <= w_len_nxt;
      r_word_cnt    <= w_word_cnt_nxt;
      r_step_cnt    <= w_step_cnt_nxt;
      r_wr_vld_p1   <= w_wr_vld_p0;
      r_inv_done_p1 <= w_inv_done_p0;
      if (w_wr_vld_p0) r_wr_data_p1 <= cfg_din;
      if (w_inv_done_p0) r_inv_count <= r_inv_count + 16'd1;
    end
  end

  assign npu_sched_write_en = r_wr_vld_p1;
  assign npu_sched_din      = r_wr_data_p1;
  assign npu_state_compute  = (r_state == S_COMPUTE);
  assign npu_busy           = (r_state == S_COMPUTE);
  assign npu_cfg_done       = (r_state == S_READY) || (r_state == S_COMPUTE);
  assign cfg_err            = (r_state == S_ERR);
  assign npu_inv_done       = r_inv_done_p1;
  assign inv_count          = r_inv_count;

endmodule
